mips_iterative_alu: RTL
=======================

Name: mips_iterative_alu

Overview:
- Parametrised, registered successor to the single-cycle MIPS datapath ALU.
- Adds a Start/Busy/Done handshake and iterative multicycle unsigned multiply and divide.
- MUL and DIVU return full-width HI/LO results.
- Sits in the EX stage of the multicycle MIPS core; the controller stalls on Busy.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be >= 4 and even.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high. Clears all state.
- Start  input  1  operation request; sampled only in IDLE.
- SrcA  input  DATA_WIDTH  operand A (dividend/multiplicand); captured when Start is accepted.
- SrcB  input  DATA_WIDTH  operand B (divisor/multiplier); captured when Start is accepted.
- ALU_Control  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 DIVU, 100 SUB, 101 MUL, 110 SLT, 111 NOR.
- ALU_Result  output  DATA_WIDTH  LO result: logic/arith result, low product, or quotient.
- Hi_Result  output  DATA_WIDTH  HI result: high product or remainder; 0 for single-cycle ops.
- Zero  output  1  high when registered ALU_Result is all zeros.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when results become valid.
- Div_By_Zero  output  1  set on DIVU with SrcB==0; held until the next accepted Start.

Behaviour:
- Reset (async, RST=1):
  - State=IDLE.
  - ALU_Result=0, Hi_Result=0, Busy=0, Done=0, Div_By_Zero=0, counter=0.
  - Zero=1, since it follows the zeroed ALU_Result.
  - RST asserted mid-operation aborts it; no Done is issued.
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- Acceptance:
  - Start is accepted only in IDLE.
  - SrcA, SrcB and ALU_Control are latched internally on acceptance.
  - Start while Busy=1 is ignored, not queued.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, plus DIVU with SrcB==0):
  - Accept at edge N -> FINISH.
  - Results registered at edge N; Done=1 for the following cycle; state returns to IDLE at edge N+1.
  - Busy stays 0 for these ops.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
  - SLT is signed two's-complement compare; result is 1 or 0, zero-extended.
  - NOR is ~(A|B).
- MUL (unsigned shift-add, one bit per cycle):
  - Accept -> MUL_RUN with counter=DATA_WIDTH; Busy=1.
  - Each cycle processes one multiplier bit and decrements the counter.
  - At counter==0 -> FINISH. Done is asserted DATA_WIDTH+1 cycles after acceptance.
  - {Hi_Result, ALU_Result} = full 2*DATA_WIDTH-bit product.
- DIVU (unsigned restoring division, one quotient bit per cycle):
  - Same timing as MUL.
  - ALU_Result = quotient, Hi_Result = remainder.
- DIVU with SrcB==0:
  - No iteration; same timing as a single-cycle op.
  - ALU_Result = all ones, Hi_Result = SrcA, Div_By_Zero = 1.
- Output holding:
  - ALU_Result, Hi_Result, Zero and Div_By_Zero change only at result-write time in FINISH entry.
  - They hold their values otherwise, including during Busy.
  - Internal partial products and remainders are not visible on the outputs.
- Done and Busy are mutually exclusive. Busy falls on the same edge that Done rises.
- Start asserted in the same cycle Done=1 is ignored (state is FINISH). The earliest new accept is the next cycle in IDLE.
- Operand changes after acceptance have no effect on the running operation.

Test Plan:
- Reset mid-operation:
  - Stimulus: RST pulse during MUL iteration 10 (A=7, B=9).
  - Required: Busy=0, Done never pulses, ALU_Result=0, Zero=1.
  - Then Start ADD with A=5, B=3 -> next cycle Done=1, ALU_Result=8.
- Single-cycle ops:
  - SUB A=3, B=3 -> ALU_Result=0, Zero=1, Done one cycle after accept.
  - SLT A=0xFFFFFFFF, B=1 -> ALU_Result=1.
  - NOR A=0, B=0 -> ALU_Result=0xFFFFFFFF.
- Full-width MUL:
  - Stimulus: A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Required: Busy high for 32 cycles, Done at cycle 33, Hi_Result=0xFFFFFFFE, ALU_Result=0x00000001.
- DIVU:
  - A=100, B=7 -> after 33 cycles ALU_Result=14, Hi_Result=2, Div_By_Zero=0.
  - A=5, B=0 -> Done after 1 cycle, ALU_Result=0xFFFFFFFF, Hi_Result=5, Div_By_Zero=1.
- Handshake and operand isolation:
  - Stimulus: pulse Start with a new op every cycle during a DIVU; change SrcA/SrcB mid-run.
  - Required: ignored, with exactly one Done and the original quotient.
  - Start during the Done cycle is ignored; the next-cycle Start is accepted.
- Parametrisation:
  - Stimulus: DATA_WIDTH=8, MUL A=0xF0, B=0x11.
  - Required: Done after 9 cycles, Hi_Result=0x0F, ALU_Result=0xF0.

Source files
------------

// File: rtl/mips_iterative_alu.sv
// Registered EX-stage ALU for the multicycle MIPS core. Logic and add/sub ops
// finish in one cycle; unsigned MUL and DIVU iterate one bit per cycle and
// return full-width HI/LO results behind a Start/Busy/Done handshake.
module mips_iterative_alu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [2:0]            ALU_Control,
  output logic [DATA_WIDTH-1:0] ALU_Result,
  output logic [DATA_WIDTH-1:0] Hi_Result,
  output logic                  Zero,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Div_By_Zero
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_DIVU = 3'b011,
    OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLT = 3'b110, OP_NOR  = 3'b111
  } op_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DATA_WIDTH);

  state_t                state, state_nxt;
  op_t                   op;
  logic [CNT_WIDTH-1:0]  cnt;
  // hi_w: accumulator (MUL) or partial remainder (DIVU)
  // lo_w: multiplier/low product (MUL) or dividend/quotient (DIVU)
  logic [DATA_WIDTH-1:0] hi_w, lo_w, opb;
  logic [DATA_WIDTH-1:0] hi_step, lo_step;
  logic [DATA_WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [DATA_WIDTH-1:0] sc_res, sc_hi;
  logic                  accept, div_zero, last_iter, slt_bit;

  assign op        = op_t'(ALU_Control);
  assign accept    = (state == IDLE) && Start;
  assign div_zero  = (op == OP_DIVU) && (SrcB == '0);
  assign last_iter = (cnt == CNT_ONE);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (op == OP_MUL)                    state_nxt = MUL_RUN;
          else if (op == OP_DIVU && !div_zero) state_nxt = DIV_RUN;
          else                                 state_nxt = FINISH;
        end
      end
      MUL_RUN, DIV_RUN: begin
        Busy = 1'b1;
        if (last_iter) state_nxt = FINISH;
      end
      FINISH: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add or restoring-divide step per cycle
  always_comb begin
    mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opb} : '0);
    div_shift = {hi_w, lo_w[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    hi_step   = hi_w;
    lo_step   = lo_w;
    if (state == MUL_RUN) begin
      hi_step = mul_sum[DATA_WIDTH:1];
      lo_step = {mul_sum[0], lo_w[DATA_WIDTH-1:1]};
    end else if (state == DIV_RUN) begin
      // A clear top bit of the difference means the shifted remainder
      // was >= divisor, so the subtraction sticks and the quotient bit is 1.
      if (!div_diff[DATA_WIDTH]) begin
        hi_step = div_diff[DATA_WIDTH-1:0];
        lo_step = {lo_w[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[DATA_WIDTH-1:0];
        lo_step = {lo_w[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Single-cycle results, computed straight from the operands at accept
  always_comb begin
    slt_bit = $signed(SrcA) < $signed(SrcB);
    sc_res  = '0;
    sc_hi   = '0;
    case (op)
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_ADD:  sc_res = SrcA + SrcB;
      OP_SUB:  sc_res = SrcA - SrcB;
      OP_SLT:  sc_res[0] = slt_bit;
      OP_NOR:  sc_res = ~(SrcA | SrcB);
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = SrcA;
      end
      default: sc_res = '0;
    endcase
  end

  // Operand capture, iteration registers and result write on FINISH entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_w        <= '0;
      lo_w        <= '0;
      opb         <= '0;
      cnt         <= '0;
      ALU_Result  <= '0;
      Hi_Result   <= '0;
      Zero        <= 1'b1;
      Div_By_Zero <= 1'b0;
    end else if (accept) begin
      Div_By_Zero <= div_zero;
      if (op == OP_MUL) begin
        hi_w <= '0;
        lo_w <= SrcB;
        opb  <= SrcA;
        cnt  <= CNT_INIT;
      end else if (op == OP_DIVU && !div_zero) begin
        hi_w <= '0;
        lo_w <= SrcA;
        opb  <= SrcB;
        cnt  <= CNT_INIT;
      end else begin
        ALU_Result <= sc_res;
        Hi_Result  <= sc_hi;
        Zero       <= (sc_res == '0);
      end
    end else if (state == MUL_RUN || state == DIV_RUN) begin
      hi_w <= hi_step;
      lo_w <= lo_step;
      cnt  <= cnt - CNT_ONE;
      if (last_iter) begin
        ALU_Result <= lo_step;
        Hi_Result  <= hi_step;
        Zero       <= (lo_step == '0);
      end
    end
  end

endmodule
